crack_scheduler: RTL
====================

CRACK_SCHEDULER -- requirements
Module: crack_scheduler

Interface
REQ-001 Parameter NCORES, default 2: number of parallel crack cores served, legal range 1..8.
REQ-002 Parameter KEY_W, default 24: key width in bits.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  start-search pulse; accepted only while rdy=1.
REQ-006 rdy  output  1  scheduler idle, ready for en.
REQ-007 key  output  KEY_W  matching key; valid when key_valid=1.
REQ-008 key_valid  output  1  last search found a key.
REQ-009 key_nf  output  1  last search exhausted the key space with no match.
REQ-010 core_en  output  NCORES  one-cycle dispatch pulse per core.
REQ-011 core_key  output  NCORES*KEY_W  key to test, core i at slice [i*KEY_W +: KEY_W]; held from dispatch until that core's done.
REQ-012 core_rdy  input  NCORES  core i idle and able to accept core_en.
REQ-013 core_done  input  NCORES  one-cycle pulse: core i finished its key.
REQ-014 core_match  input  NCORES  qualified by core_done: core i's key decrypted to valid plaintext.
REQ-015 core_abort  output  1  one-cycle pulse: all cores abandon current work.
REQ-016 ct_req  input  NCORES  core i requests a ciphertext-memory read.
REQ-017 ct_addr_in  input  NCORES*8  requested address, core i at slice [i*8 +: 8].
REQ-018 ct_gnt  output  NCORES  one-hot grant, combinational, same cycle as request.
REQ-019 ct_addr  output  8  address to the shared ciphertext memory = ct_addr_in of the granted core, 0 when no grant.

Function
REQ-020 States IDLE, RUN, ABORT; reset state IDLE.
REQ-021 IDLE: rdy=1; en=1 -> next_key=0, busy=0, key_valid=0, key_nf=0, key=0, go RUN next cycle.
REQ-022 en while rdy=0 SHALL be ignored with no state change.
REQ-023 RUN: each cycle at most one dispatch, to the lowest index i with core_rdy[i]=1 and busy[i]=0, while next_key < 2^KEY_W.
REQ-024 Dispatch: core_en[i]=1 for one cycle, core_key slice i <= next_key, busy[i] set, next_key += 1; next_key is KEY_W+1 bits, no wrap.
REQ-025 core_done[i] clears busy[i] in the same edge; a core whose busy bit clears that cycle is not dispatched until the following cycle.
REQ-026 core_done[i] with core_match[i]=1: key <= core_key slice i, go ABORT; for simultaneous matches the smallest key value wins.
REQ-027 core_done with core_match=0 for a core with busy=0 SHALL be ignored.
REQ-028 RUN, next_key = 2^KEY_W and busy all zero with no match that cycle -> key_nf=1, go IDLE.
REQ-029 ABORT: core_abort=1 on the first ABORT cycle only; no dispatch; busy cleared; remain until core_rdy all ones, then key_valid=1, go IDLE.
REQ-030 key, key_valid, key_nf SHALL hold their values in IDLE until the next accepted en.
REQ-031 ct arbiter round-robin: a rotating pointer p; the grant goes to the first requester at or after p modulo NCORES; after a grant to core g, p = g+1 modulo NCORES.
REQ-032 Arbitration active in every state; a single requester is granted every cycle it requests; a requester holds ct_req and ct_addr_in until granted; read data returns one cycle after grant, broadcast to all cores.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, rdy=1, key=0, key_valid=0, key_nf=0, core_en=0, core_key=0, core_abort=0, busy=0, next_key=0, ct_gnt=0, ct_addr=0, arbiter pointer=0, regardless of clk.
REQ-034 Reset during RUN or ABORT SHALL discard the search; no result flag is asserted after release.

Verification
REQ-035 NCORES=2, both core_rdy=1, en pulse -> core_en[0] with key 0x000000, then core_en[1] with key 0x000001 next cycle; rdy=0.
REQ-036 Core 1 done with match on key 0x000001 -> core_abort pulse; after both core_rdy=1, key=0x000001, key_valid=1, rdy=1.
REQ-037 Same-cycle match on core 0 (key 0x000004) and core 1 (key 0x000003) -> key=0x000003.
REQ-038 KEY_W=4, all done with no match -> 16 dispatches total, keys 0x0..0xF, then key_nf=1, key_valid=0.
REQ-039 ct_req=2'b11 held 4 cycles, pointer 0 -> ct_gnt 01,10,01,10; ct_addr tracks the granted core's address.
REQ-040 rst_n low mid-RUN after 5 dispatches -> outputs at reset values at once; new en restarts at key 0x000000.

Source files
------------

// File: rtl/crack_scheduler.sv
// crack_scheduler: hands sequential keys to parallel crack cores, collects the result, arbitrates ciphertext reads
module crack_scheduler #(
    parameter int NCORES = 2,
    parameter int KEY_W  = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    output logic                    rdy,
    output logic [KEY_W-1:0]        key,
    output logic                    key_valid,
    output logic                    key_nf,
    output logic [NCORES-1:0]       core_en,
    output logic [NCORES*KEY_W-1:0] core_key,
    input  logic [NCORES-1:0]       core_rdy,
    input  logic [NCORES-1:0]       core_done,
    input  logic [NCORES-1:0]       core_match,
    output logic                    core_abort,
    input  logic [NCORES-1:0]       ct_req,
    input  logic [NCORES*8-1:0]     ct_addr_in,
    output logic [NCORES-1:0]       ct_gnt,
    output logic [7:0]              ct_addr
);
    localparam int PW = NCORES > 1 ? $clog2(NCORES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, ABORT} state_t;

    state_t            state, state_nx;
    logic [NCORES-1:0] busy, hit, disp;
    logic [KEY_W:0]    next_key;
    logic [KEY_W-1:0]  min_key;
    logic [PW-1:0]     ptr, ptr_nx;
    logic              exhausted;

    assign rdy       = (state == IDLE);
    assign hit       = core_done & core_match & busy;
    assign exhausted = next_key[KEY_W] && busy == '0 && hit == '0;

    // Smallest key among the cores reporting a match this cycle
    always_comb begin
        min_key = '1;
        for (int i = 0; i < NCORES; i++)
            if (hit[i] && core_key[i*KEY_W +: KEY_W] < min_key) min_key = core_key[i*KEY_W +: KEY_W];
    end

    // At most one dispatch per cycle, to the lowest idle core; held off while a match is taken
    always_comb begin
        disp = '0;
        for (int i = 0; i < NCORES; i++)
            if (disp == '0 && state == RUN && hit == '0 && !next_key[KEY_W] && core_rdy[i] && !busy[i])
                disp[i] = 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en) state_nx = RUN;
            RUN:     state_nx = hit != '0 ? ABORT : (exhausted ? IDLE : RUN);
            ABORT:   if (&core_rdy) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Search datapath: key counter, busy tracking, dispatch registers and result flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key        <= '0;
            key_valid  <= 1'b0;
            key_nf     <= 1'b0;
            core_en    <= '0;
            core_key   <= '0;
            core_abort <= 1'b0;
            busy       <= '0;
            next_key   <= '0;
        end else begin
            core_en    <= disp;
            core_abort <= 1'b0;
            case (state)
                IDLE: if (en) begin
                    next_key  <= '0;
                    busy      <= '0;
                    key       <= '0;
                    key_valid <= 1'b0;
                    key_nf    <= 1'b0;
                end
                RUN: begin
                    busy <= (busy & ~core_done) | disp;
                    if (disp != '0) next_key <= next_key + (KEY_W+1)'(1);
                    for (int i = 0; i < NCORES; i++)
                        if (disp[i]) core_key[i*KEY_W +: KEY_W] <= next_key[KEY_W-1:0];
                    if (hit != '0) begin
                        key        <= min_key;
                        busy       <= '0;
                        core_abort <= 1'b1;
                    end else if (exhausted) key_nf <= 1'b1;
                end
                ABORT: begin
                    busy <= '0;
                    if (&core_rdy) key_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Round-robin ciphertext arbiter: first requester at or after the pointer wins
    always_comb begin
        ct_gnt  = '0;
        ct_addr = '0;
        ptr_nx  = ptr;
        if (rst_n)
            for (int k = 0; k < NCORES; k++)
                for (int i = 0; i < NCORES; i++)
                    if (ct_gnt == '0 && i == (int'(ptr) + k) % NCORES && ct_req[i]) begin
                        ct_gnt[i] = 1'b1;
                        ct_addr   = ct_addr_in[i*8 +: 8];
                        ptr_nx    = PW'((i + 1) % NCORES);
                    end
    end

    // Arbiter pointer moves past the last granted core
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr <= '0;
        else        ptr <= ptr_nx;
endmodule
